// File: rtl/ws2812b_pkg.sv
// Shared WS2812B protocol constants and receiver state codes.
package ws2812b_pkg;

  localparam int CYCLES_SHORT     = 4;
  localparam int CYCLES_LONG      = 6;
  localparam int CYCLES_THRESHOLD = (CYCLES_SHORT + CYCLES_LONG) / 2;
  localparam int CYCLES_RET       = 450;
  localparam int WORD_BITS        = 24;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t HIGH = 2'd1;
  localparam state_t LOW  = 2'd2;

endpackage

// File: rtl/ws2812b_sync_edge.sv
// Two-flop synchronizer for an asynchronous line, plus rise/fall detection
// on the synchronized level.
module ws2812b_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic serial,
  output logic line_sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic line_prev;

  // Synchronize the line, then keep one extra delayed copy to find edges
  always_ff @(posedge clk) begin
    if (reset) begin
      meta      <= 1'b0;
      line_sync <= 1'b0;
      line_prev <= 1'b0;
    end else begin
      meta      <= serial;
      line_sync <= meta;
      line_prev <= line_sync;
    end
  end

  assign rise = line_sync & ~line_prev;
  assign fall = ~line_sync & line_prev;

endmodule

// File: rtl/ws2812b_in_module.sv
// WS2812B receiver: measures high-pulse widths, decodes bits, assembles
// 24-bit words (first bit into bit 0) into a one-word buffer, and reports
// frame end on a long low gap.
module ws2812b_in_module #(
  parameter int CYCLES_THRESHOLD = ws2812b_pkg::CYCLES_THRESHOLD,
  parameter int CYCLES_MIN_HIGH  = 2,
  parameter int CYCLES_MAX_HIGH  = 12,
  parameter int CYCLES_RET       = ws2812b_pkg::CYCLES_RET,
  parameter int COUNTER_WIDTH    = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws2812b_data,
  output logic [23:0] data,
  output logic        data_available,
  input  logic        data_read,
  output logic        frame_end,
  output logic        frame_error,
  output logic        overflow,
  output logic [3:0]  debug_info
);

  import ws2812b_pkg::*;

  localparam logic [COUNTER_WIDTH-1:0] ONE_C    = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] THRESH_C = COUNTER_WIDTH'(CYCLES_THRESHOLD);
  localparam logic [COUNTER_WIDTH-1:0] MIN_C    = COUNTER_WIDTH'(CYCLES_MIN_HIGH);
  localparam logic [COUNTER_WIDTH-1:0] MAX_C    = COUNTER_WIDTH'(CYCLES_MAX_HIGH);
  localparam logic [COUNTER_WIDTH-1:0] SAT_C    = COUNTER_WIDTH'(CYCLES_MAX_HIGH + 1);
  localparam logic [COUNTER_WIDTH-1:0] RET_C    = COUNTER_WIDTH'(CYCLES_RET);
  localparam logic [COUNTER_WIDTH-1:0] RET_M1_C = COUNTER_WIDTH'(CYCLES_RET - 1);
  localparam logic [4:0]               LAST_BIT = 5'(WORD_BITS - 1);

  logic                     line_sync;
  logic                     rise;
  logic                     fall;
  state_t                   state;
  logic [COUNTER_WIDTH-1:0] high_cnt;
  logic [COUNTER_WIDTH-1:0] low_cnt;
  logic [4:0]               bit_cnt;
  logic [22:0]              shreg;
  logic                     width_ok;
  logic                     bit_val;
  logic                     word_done;
  logic [23:0]              next_word;

  ws2812b_sync_edge u_sync (
    .clk       (clk),
    .reset     (reset),
    .serial    (ws2812b_data),
    .line_sync (line_sync),
    .rise      (rise),
    .fall      (fall)
  );

  // Classify the pulse that is ending and form the word it would produce
  always_comb begin
    width_ok  = (high_cnt >= MIN_C) && (high_cnt <= MAX_C);
    bit_val   = (high_cnt >= THRESH_C);
    next_word = {bit_val, shreg};
    word_done = (state == HIGH) && fall && width_ok && (bit_cnt == LAST_BIT);
  end

  // Pulse-width FSM: tracks high/low times, shifts in bits, flags errors and gaps
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      high_cnt    <= '0;
      low_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_end   <= 1'b0;
      frame_error <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= ONE_C;
          end else if (low_cnt < RET_C) begin
            low_cnt <= low_cnt + ONE_C;
          end
        end
        HIGH: begin
          if (fall) begin
            if (!width_ok) begin
              frame_error <= 1'b1;
              bit_cnt     <= '0;
              low_cnt     <= ONE_C;
              state       <= IDLE;
            end else begin
              shreg   <= next_word[23:1];
              bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
              low_cnt <= ONE_C;
              state   <= LOW;
            end
          end else if (high_cnt < SAT_C) begin
            high_cnt <= high_cnt + ONE_C;
          end
        end
        LOW: begin
          if (rise) begin
            state    <= HIGH;
            high_cnt <= ONE_C;
          end else if (low_cnt >= RET_M1_C) begin
            frame_end   <= 1'b1;
            frame_error <= (bit_cnt != 5'd0);
            bit_cnt     <= '0;
            low_cnt     <= RET_C;
            state       <= IDLE;
          end else begin
            low_cnt <= low_cnt + ONE_C;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-word output buffer with available/read handshake and overflow report
  always_ff @(posedge clk) begin
    if (reset) begin
      data           <= '0;
      data_available <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (word_done) begin
        if (!data_available || data_read) begin
          data           <= next_word;
          data_available <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (data_read) begin
        data_available <= 1'b0;
      end
    end
  end

  assign debug_info = {data_available, frame_end, line_sync, clk};

endmodule
